// File: rtl/multi_digit_counter.sv
// Debounced up/down/clear counter of NUM_DIGITS hex or BCD digits with button
// auto-repeat and active-low 7-segment outputs.
`timescale 1ns/1ps

module multi_digit_counter #(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned DEC_MODE       = 0,
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned REPEAT_DELAY   = 12500000,
    parameter int unsigned REPEAT_PERIOD  = 2500000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic                    i_Switch_Inc,
    input  logic                    i_Switch_Dec,
    input  logic                    i_Switch_Clr,
    output logic [4*NUM_DIGITS-1:0] o_Count,
    output logic [7*NUM_DIGITS-1:0] o_Segments,
    output logic                    o_Wrap
);

    localparam int unsigned CNT_W    = 4 * NUM_DIGITS;
    localparam int unsigned DB_W     = $clog2(DEBOUNCE_LIMIT);
    localparam int unsigned TMR_TOP  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W    = (TMR_TOP > 2) ? $clog2(TMR_TOP) : 1;
    localparam int unsigned DLY_LAST = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
    localparam int unsigned PER_LAST = (REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0;
    localparam int unsigned BTN_INC  = 0;
    localparam int unsigned BTN_DEC  = 1;
    localparam int unsigned BTN_CLR  = 2;
    localparam logic [3:0]  DIG_MAX  = (DEC_MODE != 0) ? 4'd9 : 4'd15;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    logic [2:0]       raw_btn;
    logic [2:0]       sync_q1;
    logic [2:0]       sync_q2;
    logic [2:0]       filt_q;
    logic [2:0]       filt_d_q;
    logic [2:0]       rise_c;
    logic [DB_W-1:0]  db_cnt_q [3];
    logic [1:0]       step_c;
    logic [CNT_W-1:0] count_q;
    logic             wrap_q;
    logic [CNT_W-1:0] inc_val_c;
    logic [CNT_W-1:0] dec_val_c;
    logic             inc_wrap_c;
    logic             dec_wrap_c;
    logic             carry_c;
    logic             borrow_c;

    assign raw_btn = {i_Switch_Clr, i_Switch_Dec, i_Switch_Inc};
    assign rise_c  = filt_q & ~filt_d_q;

    // Synchronise and debounce all three buttons; any agreement restarts the count
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q1  <= '0;
            sync_q2  <= '0;
            filt_q   <= '0;
            filt_d_q <= '0;
            for (int b = 0; b < 3; b++) db_cnt_q[b] <= '0;
        end else begin
            sync_q1  <= raw_btn;
            sync_q2  <= sync_q1;
            filt_d_q <= filt_q;
            for (int b = 0; b < 3; b++) begin
                if (sync_q2[b] != filt_q[b]) begin
                    if (db_cnt_q[b] == DB_W'(DEBOUNCE_LIMIT - 1)) begin
                        filt_q[b]   <= sync_q2[b];
                        db_cnt_q[b] <= '0;
                    end else begin
                        db_cnt_q[b] <= db_cnt_q[b] + DB_W'(1);
                    end
                end else begin
                    db_cnt_q[b] <= '0;
                end
            end
        end
    end

    // Auto-repeat sequencer for the increment and decrement buttons
    for (genvar g = 0; g < 2; g++) begin : g_rpt
        rpt_state_e       state_q;
        logic [TMR_W-1:0] tmr_q;

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                state_q <= RPT_IDLE;
                tmr_q   <= '0;
            end else if (!filt_q[g]) begin
                state_q <= RPT_IDLE;
                tmr_q   <= '0;
            end else begin
                case (state_q)
                    RPT_IDLE: begin
                        if (rise_c[g]) begin
                            state_q <= RPT_DELAY;
                            tmr_q   <= '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (REPEAT_DELAY != 0) begin
                            if (tmr_q == TMR_W'(DLY_LAST)) begin
                                state_q <= RPT_REPEAT;
                                tmr_q   <= '0;
                            end else begin
                                tmr_q <= tmr_q + TMR_W'(1);
                            end
                        end
                    end
                    RPT_REPEAT: begin
                        if (tmr_q == TMR_W'(PER_LAST)) tmr_q <= '0;
                        else                           tmr_q <= tmr_q + TMR_W'(1);
                    end
                    default: begin
                        state_q <= RPT_IDLE;
                        tmr_q   <= '0;
                    end
                endcase
            end
        end

        assign step_c[g] = (state_q == RPT_IDLE)  ? rise_c[g] :
                           (state_q == RPT_DELAY) ? (filt_q[g] && (REPEAT_DELAY != 0) &&
                                                     (tmr_q == TMR_W'(DLY_LAST))) :
                           ((state_q == RPT_REPEAT) && filt_q[g] && (tmr_q == TMR_W'(PER_LAST)));
    end

    // Ripple carry/borrow next values; a surviving carry/borrow means wrap
    always_comb begin
        inc_val_c = count_q;
        dec_val_c = count_q;
        carry_c   = 1'b1;
        borrow_c  = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (carry_c) begin
                if (count_q[4*d +: 4] == DIG_MAX) begin
                    inc_val_c[4*d +: 4] = 4'd0;
                end else begin
                    inc_val_c[4*d +: 4] = count_q[4*d +: 4] + 4'd1;
                    carry_c = 1'b0;
                end
            end
            if (borrow_c) begin
                if (count_q[4*d +: 4] == 4'd0) begin
                    dec_val_c[4*d +: 4] = DIG_MAX;
                end else begin
                    dec_val_c[4*d +: 4] = count_q[4*d +: 4] - 4'd1;
                    borrow_c = 1'b0;
                end
            end
        end
        inc_wrap_c = carry_c;
        dec_wrap_c = borrow_c;
    end

    // Clear wins over steps; simultaneous inc and dec cancel
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (rise_c[BTN_CLR]) begin
                count_q <= '0;
            end else if (step_c[BTN_INC] && !step_c[BTN_DEC]) begin
                count_q <= inc_val_c;
                wrap_q  <= inc_wrap_c;
            end else if (step_c[BTN_DEC] && !step_c[BTN_INC]) begin
                count_q <= dec_val_c;
                wrap_q  <= dec_wrap_c;
            end
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0: seg_decode = 7'b0000001;
            4'h1: seg_decode = 7'b1001111;
            4'h2: seg_decode = 7'b0010010;
            4'h3: seg_decode = 7'b0000110;
            4'h4: seg_decode = 7'b1001100;
            4'h5: seg_decode = 7'b0100100;
            4'h6: seg_decode = 7'b0100000;
            4'h7: seg_decode = 7'b0001111;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0000100;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b1100000;
            4'hC: seg_decode = 7'b0110001;
            4'hD: seg_decode = 7'b1000010;
            4'hE: seg_decode = 7'b0110000;
            default: seg_decode = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        o_Segments = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            o_Segments[7*d +: 7] = seg_decode(count_q[4*d +: 4]);
        end
    end

    assign o_Count = count_q;
    assign o_Wrap  = wrap_q;

endmodule

// File: doc/multi_digit_counter.md
MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 2: number of 4-bit digits and 7-segment displays, legal range 1..8.
REQ-002 Parameter DEC_MODE, default 0: 0 selects hex digits (0-F); 1 selects decimal digits (0-9).
REQ-003 Parameter DEBOUNCE_LIMIT, default 250000: number of consecutive stable clocks required to accept a button change, minimum 2.
REQ-004 Parameter REPEAT_DELAY, default 12500000: clocks an accepted increment or decrement button must stay held before auto-repeat starts, 0 disables auto-repeat.
REQ-005 Parameter REPEAT_PERIOD, default 2500000: clocks between auto-repeat steps, minimum 1.
REQ-006 Port i_Clk, input, 1 bit: sole clock, all state is updated on its rising edge.
REQ-007 Port i_Rst_L, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 Port i_Switch_Inc, input, 1 bit: raw increment button, active-high, asynchronous to i_Clk.
REQ-009 Port i_Switch_Dec, input, 1 bit: raw decrement button, active-high.
REQ-010 Port i_Switch_Clr, input, 1 bit: raw clear button, active-high.
REQ-011 Port o_Count, output, 4*NUM_DIGITS bits: registered digit values, digit k occupies bits [4k+3:4k], digit 0 is least significant.
REQ-012 Port o_Segments, output, 7*NUM_DIGITS bits: active-low segments; for digit k, bit 7k+6 = A down to bit 7k = G.
REQ-013 Port o_Wrap, output, 1 bit: one-clock pulse when the count wraps in either direction.

Function
REQ-014 Each raw button passes through a 2-flop synchroniser, then a debouncer whose filtered output takes the synchronised value only after DEBOUNCE_LIMIT consecutive clocks of disagreement with the current filtered value; any agreement clears the stability counter.
REQ-015 A press event is a 0->1 transition of a filtered button; the count changes on the clock after the filtered value rises.
REQ-016 Auto-repeat per inc/dec button: FSM states IDLE, DELAY, REPEAT.
- IDLE -> DELAY on a press event, which issues one step.
- DELAY -> REPEAT after REPEAT_DELAY clocks held, which issues one step.
- In REPEAT, one step is issued every REPEAT_PERIOD clocks.
- Filtered release -> IDLE from any state.
- REPEAT_DELAY = 0 disables auto-repeat and keeps the FSM between IDLE and DELAY.
REQ-017 Priority within a clock cycle:
- A clear event (filtered clear rising) sets every digit to 0 and suppresses steps that cycle.
- An increment step and a decrement step arriving together cancel, leaving the count unchanged.
REQ-018 Increment is ripple-carry across digits. A digit at its maximum (F hex, 9 decimal) becomes 0 and carries into the next digit. All other digits hold.
REQ-019 Decrement is ripple-borrow. A digit at 0 becomes its maximum and borrows from the next digit.
REQ-020 Wrap behaviour:
- Incrementing with all digits at maximum yields all zeros.
- Decrementing all zeros yields all digits at maximum.
- Either case asserts o_Wrap for exactly that update clock.
- A clear never asserts o_Wrap.
REQ-021 o_Segments is decoded combinationally from o_Count, standard hex 7-segment patterns with A-G active-low. Examples: 0 -> A-F on, G off; 1 -> B,C on.
REQ-022 In DEC_MODE=1, digit values above 9 are unreachable.
REQ-023 The clear button has no auto-repeat; holding it clears only once.

Reset
REQ-024 While i_Rst_L is low, the block holds the following state asynchronously:
- o_Count = 0 and o_Wrap = 0.
- Synchroniser flops, filtered buttons and stability counters = 0.
- Auto-repeat FSMs = IDLE and their timers = 0.
REQ-025 o_Segments shows 0 on every digit during reset.
REQ-026 Reset asserted mid-operation aborts any debounce or repeat in progress.
REQ-027 After reset deasserts, a button already held high is treated as a new press once it has been stable for DEBOUNCE_LIMIT clocks.

Verification (bench uses NUM_DIGITS=2, DEBOUNCE_LIMIT=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-028 Bounce: toggle Inc every 2 clocks for 40 clocks, then hold 10 clocks -> o_Count goes 0x00 -> 0x01 exactly once.
REQ-029 Carry and wrap: hex mode, count preset to 0x0F by 15 presses, one more Inc -> 0x10. Continue to 0xFF, one more Inc -> 0x00 with a single-clock o_Wrap.
REQ-030 Decimal borrow: DEC_MODE=1 at 0x00, one Dec -> 0x99 with o_Wrap = 1. Next Dec -> 0x98, o_Segments[6:0] = pattern for 8 (all segments low).
REQ-031 Auto-repeat: hold Inc 50 clocks after its filtered rise -> 1 + 1 + 6 = 8 steps at the stated offsets. Release -> no further steps.
REQ-032 Simultaneous events:
- Inc and Dec filtered-rise in the same clock -> count unchanged.
- Clr together with Inc -> 0x00 with o_Wrap = 0.
REQ-033 Reset mid-operation: pull i_Rst_L low during REPEAT at count 0x37 -> o_Count = 0x00 immediately, without waiting for a clock edge. After release with Inc still held, exactly one step occurs after DEBOUNCE_LIMIT + 3 clocks.
